// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types, defaults and element indexing for the systolic-array feeder
package sa_pkg;

    localparam int SA_DW = 8;
    localparam int SA_N  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_DRAIN,
        ST_RESULT
    } state_t;

    // Bit offset of element (r,c) in a row-major packed N x N frame.
    function automatic int elem_off(input int r, input int c, input int n, input int dw);
        return (r * n + c) * dw;
    endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// rtl/sa_skew_lane.sv - one diagonally skewed lane: emits row element (k-LANE) while in range, else 0
module sa_skew_lane
    import sa_pkg::*;
#(
    parameter int DW   = SA_DW,
    parameter int N    = SA_N,
    parameter int LANE = 0,
    parameter int KW   = 3
) (
    input  logic            en,
    input  logic [KW-1:0]   k,
    input  logic [N*DW-1:0] row_d,
    input  logic [N*DW-1:0] row_w,
    output logic [DW-1:0]   d,
    output logic [DW-1:0]   w
);

    always_comb begin
        d = '0;
        w = '0;
        if (en) begin
            for (int c = 0; c < N; c++) begin
                if (int'(k) == LANE + c) begin
                    d = row_d[elem_off(0, c, N, DW) +: DW];
                    w = row_w[elem_off(0, c, N, DW) +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/sa3x3_feeder.sv
// rtl/sa3x3_feeder.sv - frame sequencer feeding sa3x3; SA_FEEDER_WEIGHT_HOLD_EN adds w_load kernel reuse
module sa3x3_feeder
    import sa_pkg::*;
#(
    parameter int DW      = SA_DW,
    parameter int N       = SA_N,
    parameter int RES_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] din_vec,
    input  logic [N*N*DW-1:0] win_vec,
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
    input  logic              w_load,
`endif
    output logic              sa_clear,
    output logic [DW-1:0]     din0,
    output logic [DW-1:0]     din1,
    output logic [DW-1:0]     din2,
    output logic [DW-1:0]     win0,
    output logic [DW-1:0]     win1,
    output logic [DW-1:0]     win2,
    input  logic [DW-1:0]     sa_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res,
    output logic              busy
);

    localparam int KW  = $clog2(2 * N);
    localparam int DCW = (RES_LAT > 0) ? $clog2(RES_LAT + 1) : 1;
    localparam int LN  = (N > 3) ? N : 3;
    localparam logic [KW-1:0]  K_LAST = KW'(2 * N - 2);
    localparam logic [DCW-1:0] D_LOAD = DCW'((RES_LAT > 0) ? RES_LAT - 1 : 0);

    state_t             state, state_nxt;
    logic [KW-1:0]      k, k_nxt;
    logic [DCW-1:0]     dcnt, dcnt_nxt;
    logic [N*N*DW-1:0]  frame_d, frame_w;
    logic [DW-1:0]      lane_d [LN];
    logic [DW-1:0]      lane_w [LN];
    logic [DW-1:0]      din_q  [LN];
    logic [DW-1:0]      win_q  [LN];
    logic               accept, feed_nxt, capture;

    assign accept   = in_valid && in_ready;
    assign feed_nxt = (state_nxt == ST_FEED);
    assign capture  = (state_nxt == ST_RESULT) && (state != ST_RESULT);

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dcnt_nxt  = dcnt;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                state_nxt = ST_FEED;
                k_nxt     = '0;
            end
            ST_FEED: begin
                if (k == K_LAST) begin
                    k_nxt     = '0;
                    dcnt_nxt  = D_LOAD;
                    state_nxt = (RES_LAT == 0) ? ST_RESULT : ST_DRAIN;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt == '0) state_nxt = ST_RESULT;
                else            dcnt_nxt  = dcnt - DCW'(1);
            end
            ST_RESULT: begin
                if (res_valid && res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lanes are computed from the next-state counter so the registered lane outputs line up with FEED.
    for (genvar i = 0; i < LN; i++) begin : g_lane
        if (i < N) begin : g_act
            sa_skew_lane #(
                .DW   (DW),
                .N    (N),
                .LANE (i),
                .KW   (KW)
            ) u_lane (
                .en    (feed_nxt),
                .k     (k_nxt),
                .row_d (frame_d[elem_off(i, 0, N, DW) +: N*DW]),
                .row_w (frame_w[elem_off(i, 0, N, DW) +: N*DW]),
                .d     (lane_d[i]),
                .w     (lane_w[i])
            );
        end else begin : g_pad
            assign lane_d[i] = '0;
            assign lane_w[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            dcnt      <= '0;
            frame_d   <= '0;
            frame_w   <= '0;
            in_ready  <= 1'b1;
            sa_clear  <= 1'b0;
            res_valid <= 1'b0;
            res       <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < LN; i++) begin
                din_q[i] <= '0;
                win_q[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            dcnt      <= dcnt_nxt;
            sa_clear  <= (state_nxt == ST_CLR);
            res_valid <= (state_nxt == ST_RESULT);
            busy      <= (state_nxt != ST_IDLE);
            // in_ready re-arms one cycle after the FSM has settled back in IDLE.
            in_ready  <= (state == ST_IDLE) && !accept;
            if (accept) begin
                frame_d <= din_vec;
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
                if (w_load) frame_w <= win_vec;
`else
                frame_w <= win_vec;
`endif
            end
            if (capture) res <= sa_out;
            for (int i = 0; i < LN; i++) begin
                din_q[i] <= lane_d[i];
                win_q[i] <= lane_w[i];
            end
        end
    end

    assign din0 = din_q[0];
    assign din1 = din_q[1];
    assign din2 = din_q[2];
    assign win0 = win_q[0];
    assign win1 = win_q[1];
    assign win2 = win_q[2];

endmodule

// File: tb/tb_sa3x3_feeder.sv
// tb/tb_sa3x3_feeder.sv - scoreboard bench for sa3x3_feeder lane skew, result capture and handshakes
module tb_sa3x3_feeder;

    localparam int DW      = 8;
    localparam int N       = 3;
    localparam int RES_LAT = 3;
    localparam int NF      = 2 * N - 1;
    localparam int FW      = N * N * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, sa_clear, res_valid, res_ready, busy;
    logic [FW-1:0] din_vec, win_vec;
    logic [DW-1:0] din0, din1, din2, win0, win1, win2, sa_out, res;
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
    logic          w_load;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6*DW-1:0] lane_q [$];
    logic [DW-1:0]   res_q  [$];
    logic [FW-1:0]   kern_m;

    always @(posedge clk) cyc <= cyc + 1;

    sa3x3_feeder #(.DW(DW), .N(N), .RES_LAT(RES_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_vec   (din_vec),
        .win_vec   (win_vec),
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
        .w_load    (w_load),
`endif
        .sa_clear  (sa_clear),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .win0      (win0),
        .win1      (win1),
        .win2      (win2),
        .sa_out    (sa_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6*DW-1:0] lanes_now();
        return {din0, din1, din2, win0, win1, win2};
    endfunction

    function automatic logic [FW-1:0] seq_frame(input int base);
        logic [FW-1:0] f;
        for (int e = 0; e < N * N; e++) f[e*DW +: DW] = DW'(base + e);
        return f;
    endfunction

    function automatic logic [FW-1:0] fill_frame(input logic [DW-1:0] v);
        logic [FW-1:0] f;
        for (int e = 0; e < N * N; e++) f[e*DW +: DW] = v;
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int e = 0; e < N * N; e++) f[e*DW +: DW] = DW'($urandom_range(1, 255));
        return f;
    endfunction

    task automatic push_frame(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic [DW-1:0] val);
        logic [6*DW-1:0] e;
        int c;
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
        if (w_load) kern_m = b;
`else
        kern_m = b;
`endif
        for (int k = 0; k < NF; k++) begin
            e = '0;
            for (int i = 0; i < 3; i++) begin
                c = k - i;
                if (c >= 0 && c < N) begin
                    e[(5-i)*DW +: DW] = a[(i*N + c)*DW +: DW];
                    e[(2-i)*DW +: DW] = kern_m[(i*N + c)*DW +: DW];
                end
            end
            lane_q.push_back(e);
        end
        res_q.push_back(val);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sa_clear"}, sa_clear, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res"}, res, 0);
        check({tag, "_lanes"}, lanes_now(), 0);
    endtask

    task automatic run_frame(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic [DW-1:0] val,
                             input int hold, input bit keep, input int abort_k, output int acc_cyc);
        int t;
        logic [DW-1:0] r_exp;
        t = 0;
        while (in_ready !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", in_ready, 1);
        din_vec   = a;
        win_vec   = b;
        in_valid  = 1'b1;
        res_ready = (hold == 0);
        push_frame(a, b, val);
        acc_cyc = cyc;
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
        check("clr_pulse", sa_clear, 1);
        check("clr_in_ready", in_ready, 0);
        check("clr_busy", busy, 1);
        check("clr_lanes", lanes_now(), 0);
        for (int k = 0; k < NF; k++) begin
            @(negedge clk);
            check("feed_lanes", lanes_now(), lane_q.pop_front());
            check("feed_clr", sa_clear, 0);
            if (k == abort_k) begin
                rst = 1'b0;
                @(negedge clk);
                check_reset_outs("abort");
                rst      = 1'b1;
                in_valid = 1'b0;
                lane_q.delete();
                res_q.delete();
                return;
            end
        end
        for (int j = 0; j < RES_LAT; j++) begin
            @(negedge clk);
            check("drain_lanes", lanes_now(), 0);
            check("drain_valid", res_valid, 0);
            if (j == RES_LAT - 1) sa_out = val;
        end
        @(negedge clk);
        sa_out = '0;
        r_exp  = res_q.pop_front();
        check("res_valid", res_valid, 1);
        check("res", res, r_exp);
        check("res_in_ready", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            din_vec  = ~a;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_res", res, r_exp);
            check("bp_in_ready", in_ready, 0);
        end
        if (hold > 0) begin
            res_ready = 1'b1;
            in_valid  = 1'b0;
        end
        @(negedge clk);
        check("post_valid", res_valid, 0);
        check("post_busy", busy, 0);
        check("post_in_ready", in_ready, 0);
    endtask

    int acc_a, acc_b;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        din_vec   = '0;
        win_vec   = '0;
        sa_out    = '0;
        res_ready = 1'b1;
        kern_m    = '0;
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
        w_load    = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("rel");

        run_frame(seq_frame(1), fill_frame(8'd1), 8'd202, 0, 1'b0, -1, acc_a);
        run_frame(rand_frame(), rand_frame(), DW'($urandom_range(1, 255)), 4, 1'b0, -1, acc_a);
        run_frame(rand_frame(), rand_frame(), 8'd77, 0, 1'b0, 2, acc_a);
        run_frame(seq_frame(20), rand_frame(), 8'd55, 0, 1'b0, -1, acc_a);

        run_frame(seq_frame(100), fill_frame(8'd3), 8'd11, 0, 1'b1, -1, acc_a);
        run_frame(seq_frame(200), fill_frame(8'd5), 8'd22, 0, 1'b0, -1, acc_b);
        check("frame_period", acc_b - acc_a, 2 * N + RES_LAT + 3);

`ifdef SA_FEEDER_WEIGHT_HOLD_EN
        w_load = 1'b1;
`endif
        run_frame(seq_frame(40), fill_frame(8'd2), 8'd33, 0, 1'b0, -1, acc_a);
`ifdef SA_FEEDER_WEIGHT_HOLD_EN
        w_load = 1'b0;
`endif
        run_frame(seq_frame(60), fill_frame(8'd9), 8'd44, 0, 1'b0, -1, acc_a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
